// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
package spi_pkg;

    localparam int unsigned SPI_BYTE_W     = 8;
    localparam int unsigned SPI_CMD_RW_BIT = 7;
    localparam int unsigned SPI_BIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CMD      = 2'd1,
        RD_FETCH = 2'd2,
        DATA     = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_in_sync.sv
// Input stage for one SPI line: capture/synchronizer chain of DEPTH flops
// followed by a previous-value flop that yields single-cycle edge pulses.
module spi_in_sync #(
    parameter int unsigned DEPTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [DEPTH-1:0] chain_q;
    logic [DEPTH-1:0] chain_d;
    logic             prev_q;
    logic             prev_d;

    // Shift the raw input down the chain; remember last stage for edge detect.
    always_comb begin
        chain_d    = chain_q;
        chain_d[0] = din_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            chain_d[i] = chain_q[i-1];
        end
        prev_d = chain_q[DEPTH-1];
    end

    // Chain and previous-value registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= {DEPTH{RST_VAL}};
            prev_q  <= RST_VAL;
        end else begin
            chain_q <= chain_d;
            prev_q  <= prev_d;
        end
    end

    assign level_o = chain_q[DEPTH-1];
    assign rise_c  = chain_q[DEPTH-1] & ~prev_q;
    assign fall_c  = ~chain_q[DEPTH-1] & prev_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-3 slave that turns command/data bytes into register read/write
// strobes. Define SPI_REG_BRIDGE_SYNC_EN to put a 2-FF synchronizer on every
// SPI input (asynchronous masters); otherwise a single capture flop is used.
module spi_reg_bridge
    import spi_pkg::*;
#(
    parameter int unsigned           ADDR_W      = 7,
    parameter logic [SPI_BYTE_W-1:0] STATUS_BYTE = 8'hA5
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  spi_clk_i,
    input  logic                  spi_mosi_i,
    input  logic                  spi_cs_i,
    output logic                  spi_miso_o,
    output logic [ADDR_W-1:0]     reg_addr_o,
    output logic [SPI_BYTE_W-1:0] reg_wdata_o,
    output logic                  reg_wr_o,
    output logic                  reg_rd_o,
    input  logic [SPI_BYTE_W-1:0] reg_rdata_i,
    output logic                  busy_o
);

`ifdef SPI_REG_BRIDGE_SYNC_EN
    localparam int unsigned SYNC_DEPTH = 2;
`else
    localparam int unsigned SYNC_DEPTH = 1;
`endif

    logic sclk_lvl, sclk_rise_c, sclk_fall_c;
    logic mosi_lvl, mosi_rise_c, mosi_fall_c;
    logic cs_lvl, cs_rise_c, cs_fall_c;
    logic unused_edges_c;

    // SCLK idles high; CS resets low so a CS already low at reset release
    // never produces a falling edge and cannot start a frame.
    spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_sclk_sync (
        .clk(sys_clk), .rst(sys_rst), .din_i(spi_clk_i),
        .level_o(sclk_lvl), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
    );
    spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_mosi_sync (
        .clk(sys_clk), .rst(sys_rst), .din_i(spi_mosi_i),
        .level_o(mosi_lvl), .rise_c(mosi_rise_c), .fall_c(mosi_fall_c)
    );
    spi_in_sync #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_cs_sync (
        .clk(sys_clk), .rst(sys_rst), .din_i(spi_cs_i),
        .level_o(cs_lvl), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
    );

    assign unused_edges_c = ^{sclk_lvl, mosi_rise_c, mosi_fall_c, cs_rise_c};

    spi_state_e                 state_q, state_d;
    logic [SPI_BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SPI_BYTE_W-2:0]      rx_shift_q, rx_shift_d;
    logic [SPI_BYTE_W-1:0]      tx_shift_q, tx_shift_d;
    logic [SPI_BYTE_W-1:0]      tx_next_q, tx_next_d;
    logic                       rw_q, rw_d;
    logic [ADDR_W-1:0]          addr_q, addr_d;
    logic [SPI_BYTE_W-1:0]      wdata_q, wdata_d;
    logic                       wr_q, wr_d;
    logic                       rd_q, rd_d;
    logic                       rd_pend_q, rd_pend_d;
    logic                       miso_q, miso_d;
    logic                       busy_q, busy_d;
    logic [SPI_BYTE_W-1:0]      rx_byte_c;
    logic                       byte_done_c;

    assign rx_byte_c   = {rx_shift_q, mosi_lvl};
    assign byte_done_c = sclk_rise_c && (bit_cnt_q == SPI_BIT_CNT_W'(SPI_BYTE_W - 1));

    // Frame FSM, byte assembly, MISO shifting and strobe generation.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        tx_next_d  = tx_next_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = 1'b0;
        rd_d       = 1'b0;
        rd_pend_d  = rd_q;
        miso_d     = miso_q;

        // Read data arrives one cycle after the read strobe.
        if (rd_pend_q) begin
            tx_next_d = reg_rdata_i;
        end
        // Advance the write address once the strobe has been presented.
        if (wr_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (state_q == IDLE) begin
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            if (cs_fall_c) begin
                state_d   = CMD;
                tx_next_d = STATUS_BYTE;
            end
        end else if (cs_lvl) begin
            // Deselect aborts any partial byte; finished bytes already strobed.
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            if (sclk_fall_c) begin
                if (bit_cnt_q == '0) begin
                    miso_d     = tx_next_q[SPI_BYTE_W-1];
                    tx_shift_d = {tx_next_q[SPI_BYTE_W-2:0], 1'b0};
                end else begin
                    miso_d     = tx_shift_q[SPI_BYTE_W-1];
                    tx_shift_d = {tx_shift_q[SPI_BYTE_W-2:0], 1'b0};
                end
            end
            if (sclk_rise_c) begin
                rx_shift_d = rx_byte_c[SPI_BYTE_W-2:0];
                bit_cnt_d  = bit_cnt_q + SPI_BIT_CNT_W'(1);
            end
            if (byte_done_c) begin
                case (state_q)
                    CMD: begin
                        rw_d   = rx_byte_c[SPI_CMD_RW_BIT];
                        addr_d = rx_byte_c[ADDR_W-1:0];
                        if (rx_byte_c[SPI_CMD_RW_BIT]) begin
                            state_d = RD_FETCH;
                            rd_d    = 1'b1;
                        end else begin
                            state_d = DATA;
                        end
                    end
                    DATA: begin
                        if (rw_q) begin
                            // Prefetch the next location for the following byte.
                            addr_d = addr_q + ADDR_W'(1);
                            rd_d   = 1'b1;
                        end else begin
                            wdata_d = rx_byte_c;
                            wr_d    = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if ((state_q == RD_FETCH) && rd_pend_q) begin
                state_d = DATA;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            rx_shift_q <= '0;
            tx_shift_q <= '0;
            tx_next_q  <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            rd_pend_q  <= 1'b0;
            miso_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            tx_next_q  <= tx_next_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            rd_pend_q  <= rd_pend_d;
            miso_q     <= miso_d;
            busy_q     <= busy_d;
        end
    end

    assign spi_miso_o  = miso_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = wr_q;
    assign reg_rd_o    = rd_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: bit-banged SPI mode-3 master, register-file
// model with one-cycle read latency, and a frame-level expectation model.
module tb_spi_reg_bridge;

    localparam logic [7:0] STATUS = 8'hA5;

    typedef struct packed {
        logic       is_wr;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    logic       sys_clk   = 1'b0;
    logic       sys_rst   = 1'b1;
    logic       spi_clk   = 1'b1;
    logic       spi_mosi  = 1'b0;
    logic       spi_cs    = 1'b1;
    logic       spi_miso;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata = 8'h00;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    ev_t obs_q[$];
    ev_t exp_q[$];

    logic       rd_pend_tb = 1'b0;
    logic [6:0] rd_addr_tb = 7'h00;

    spi_reg_bridge dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .spi_clk_i  (spi_clk),
        .spi_mosi_i (spi_mosi),
        .spi_cs_i   (spi_cs),
        .spi_miso_o (spi_miso),
        .reg_addr_o (reg_addr),
        .reg_wdata_o(reg_wdata),
        .reg_wr_o   (reg_wr),
        .reg_rd_o   (reg_rd),
        .reg_rdata_i(reg_rdata),
        .busy_o     (busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t mk_ev(input logic w, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.is_wr = w;
        e.addr  = a;
        e.data  = d;
        return e;
    endfunction

    // Register file: data valid only in the cycle after the read strobe.
    always @(negedge sys_clk) begin
        if (rd_pend_tb) reg_rdata = {1'b0, rd_addr_tb} + 8'h10;
        else            reg_rdata = 8'($urandom);
        rd_pend_tb = reg_rd;
        rd_addr_tb = reg_addr;
    end

    // Strobe monitor.
    always @(negedge sys_clk) begin
        if (reg_wr || reg_rd) check("wr_rd_exclusive", 32'(reg_wr & reg_rd), 32'd0);
        if (reg_wr) obs_q.push_back(mk_ev(1'b1, reg_addr, reg_wdata));
        if (reg_rd) obs_q.push_back(mk_ev(1'b0, reg_addr, 8'h00));
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Mode 3: drive MOSI on the falling SCLK edge, sample MISO just before rise.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int b = 0; b < nbits; b++) begin
            spi_clk  = 1'b0;
            spi_mosi = tx[7-b];
            tick(int'($urandom_range(4, 6)));
            rx[7-b]  = spi_miso;
            spi_clk  = 1'b1;
            tick(int'($urandom_range(4, 6)));
        end
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int ndata, input int abort_bits);
        logic [7:0] rx;
        logic [7:0] d;
        logic [6:0] a;
        obs_q.delete();
        exp_q.delete();
        a = cmd[6:0];
        spi_cs = 1'b0;
        tick(3);
        xfer(cmd, 8, rx);
        check("miso_status", 32'(rx), 32'(STATUS));
        check("busy_frame", 32'(busy), 32'd1);
        if (cmd[7]) exp_q.push_back(mk_ev(1'b0, a, 8'h00));
        for (int i = 0; i < ndata; i++) begin
            d = 8'($urandom);
            xfer(d, 8, rx);
            if (cmd[7]) begin
                check("miso_rdata", 32'(rx), 32'({1'b0, a} + 8'h10));
                a = a + 7'd1;
                exp_q.push_back(mk_ev(1'b0, a, 8'h00));
            end else begin
                check("miso_wecho", 32'(rx), 32'(STATUS));
                exp_q.push_back(mk_ev(1'b1, a, d));
                a = a + 7'd1;
            end
        end
        if (abort_bits > 0) xfer(8'($urandom), abort_bits, rx);
        spi_cs = 1'b1;
        tick(4);
        check("busy_after_cs", 32'(busy), 32'd0);
        check("miso_after_cs", 32'(spi_miso), 32'd0);
        tick(2);
        check("strobe_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) check("strobe", 32'(obs_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        logic [7:0] cmd;
        int         nd;
        int         ab;

        tick(3);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_strobes", 32'({reg_wr, reg_rd}), 32'd0);
        sys_rst = 1'b0;
        tick(3);

        run_frame(8'h05, 1, 0);
        run_frame(8'h82, 3, 0);
        run_frame(8'h7F, 2, 0);
        run_frame(8'h03, 1, 5);
        run_frame(8'hFE, 3, 0);
        run_frame(8'h40, 2, 0);

        // Reset in the middle of a read frame.
        spi_cs = 1'b0;
        tick(3);
        xfer(8'h90, 8, rx);
        xfer(8'h00, 3, rx);
        sys_rst = 1'b1;
        tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_miso", 32'(spi_miso), 32'd0);
        check("midrst_addr", 32'(reg_addr), 32'd0);
        check("midrst_wdata", 32'(reg_wdata), 32'd0);
        check("midrst_strobes", 32'({reg_wr, reg_rd}), 32'd0);
        tick(2);
        sys_rst = 1'b0;
        obs_q.delete();
        xfer(8'h00, 5, rx);
        xfer(8'h12, 8, rx);
        xfer(8'h34, 8, rx);
        check("postrst_no_strobe", 32'(obs_q.size()), 32'd0);
        check("postrst_busy", 32'(busy), 32'd0);
        spi_cs = 1'b1;
        tick(4);
        run_frame(8'h8A, 2, 0);

        for (int f = 0; f < 24; f++) begin
            cmd = 8'($urandom);
            nd  = int'($urandom_range(0, 3));
            ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 7)) : 0;
            run_frame(cmd, nd, ab);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
